stream_fifo: RTL

//  Parametrised synchronous FIFO with valid/ready handshakes on both sides, first-word-fall-through output,

---
 rtl/interconnect_pkg.sv | 24 ++
 rtl/stream_fifo_if.sv | 32 +++
 rtl/stream_fifo_ptr.sv | 27 ++
 rtl/stream_fifo.sv | 102 ++++++++++
 4 files changed

// File: rtl/interconnect_pkg.sv
// Shared helpers and default sizes for the interconnect elastic buffers.
package interconnect_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 4;

  // Per-edge FIFO operation, bit0 = push, bit1 = pop.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width needed to hold an occupancy of 0..n inclusive.
  function automatic int level_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Valid/ready stream bundle around a FIFO: producer side, consumer side and status.
interface stream_fifo_if
  import interconnect_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
);
  localparam int LW = level_width(DEPTH);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [LW-1:0]         level;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  err_overflow;

  // The FIFO itself is the slave; the surrounding producer/consumer is the master.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, level, almost_full, almost_empty, err_overflow
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, level, almost_full, almost_empty, err_overflow
  );

endinterface

// File: rtl/stream_fifo_ptr.sv
// Wrap-around FIFO pointer: counts 0..DEPTH-1 with an explicit wrap compare.
module fifo_ptr
  import interconnect_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PW    = clog2_min1(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO with level, thresholds and flush.
// Optional sticky overflow flag enabled by defining STREAM_FIFO_ERR_EN.
module stream_fifo
  import interconnect_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_THRESH  = 3,
  parameter int AE_THRESH  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  stream_fifo_if.slave    bus
);

  localparam int PW = clog2_min1(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  fifo_op_e              op;

  // Status is decoded from the registered level only, so no input reaches an output combinationally.
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign push  = bus.in_valid & ~full;
  assign pop   = ~empty & bus.out_ready;

  always_comb begin
    op = fifo_op_e'({pop, push});
  end

  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop),
    .ptr (rd_ptr)
  );

  // Storage is never reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else if (flush) begin
      level <= '0;
    end else begin
      case (op)
        OP_PUSH: level <= level + 1'b1;
        OP_POP:  level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef STREAM_FIFO_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (flush) begin
      err_q <= 1'b0;
    end else if (bus.in_valid && full) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_overflow = err_q;
`else
  assign bus.err_overflow = 1'b0;
`endif

  assign bus.in_ready     = ~full;
  assign bus.out_valid    = ~empty;
  assign bus.out_data     = mem[rd_ptr];
  assign bus.level        = level;
  assign bus.almost_full  = (int'(level) >= AF_THRESH);
  assign bus.almost_empty = (int'(level) <= AE_THRESH);

endmodule
